// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle shared between the requesters and the 8-way
// round-robin arbiter that drives the select of an 8:1 mux path.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  gnt_valid
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output gnt_valid
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a bounded hold time.
// An owner keeps the grant until it signals done, drops its request,
// or has held for MAX_HOLD cycles while somebody else is waiting.
// On release the priority pointer moves just past the old owner, and a
// waiting requester is granted on the same edge (no idle bubble).
// All outputs are decoded purely from registered state.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last hold count an owner may reach before a waiting request forces rotation.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     r_state;
  logic [2:0] r_owner;
  logic [2:0] r_ptr;
  logic [3:0] r_hcnt;

  state_t     w_state_n;
  logic [2:0] w_owner_n;
  logic [2:0] w_ptr_n;
  logic [3:0] w_hcnt_n;
  logic [7:0] w_others;
  logic       w_release;

  // First set bit of r scanning base, base+1, ... with 3-bit wrap.
  // Walking downward lets the lowest offset overwrite the others.
  function automatic logic [2:0] rr_scan(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    rr_scan = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (r[idx]) rr_scan = idx;
    end
  endfunction

  // Next-state, owner, pointer and hold-count selection.
  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_hcnt_n  = r_hcnt;
    w_others  = bus.req & ~(8'b1 << r_owner);
    w_release = bus.done || !bus.req[r_owner] ||
                ((r_hcnt == HOLD_LAST) && (|w_others));

    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_owner_n = rr_scan(bus.req, r_ptr);
          w_hcnt_n  = 4'd0;
          w_state_n = BUSY;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_n  = r_owner + 3'd1;
          w_hcnt_n = 4'd0;
          if (|w_others) begin
            // Old owner is masked out, so it cannot win back-to-back.
            w_owner_n = rr_scan(w_others, r_owner + 3'd1);
          end else begin
            w_owner_n = 3'd0;
            w_state_n = IDLE;
          end
        end else if (r_hcnt != HOLD_LAST) begin
          w_hcnt_n = r_hcnt + 4'd1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_owner_n = 3'd0;
      end
    endcase
  end

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= 3'd0;
      r_ptr   <= 3'd0;
      r_hcnt  <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_hcnt  <= w_hcnt_n;
    end
  end

  // Owner is kept at 0 while idle, so sel reads 0 without a grant.
  assign bus.gnt_valid = (r_state == BUSY);
  assign bus.sel       = r_owner;
  assign bus.gnt       = (r_state == BUSY) ? (8'b1 << r_owner) : 8'b0;

endmodule
